// File: rtl/rom_dl_sched.sv
// rom_dl_sched: packs the byte-wide ROM download stream (ioctl_*) into 16-bit
// SDRAM words, buffers them in a small FIFO and issues them on a toggle
// request/acknowledge port. It also flags load completion and produces the
// core reset.
//
// Optional build macro: ROM_DL_CHECKSUM_EN adds a 16-bit running sum output.
//
// Ports
//   clk_sys        system clock, rising edge
//   reset          synchronous active-high reset
//   ioctl_download download in progress
//   ioctl_index    download target index (only DL_INDEX is accepted)
//   ioctl_wr       byte-write strobe (level; its rising edge is the event)
//   ioctl_addr     byte address
//   ioctl_dout     byte data
//   user_reset     OSD/button reset request
//   port_req       SDRAM request toggle
//   port_ack       SDRAM acknowledge toggle (done when equal to port_req)
//   port_a         word address
//   port_ds        byte enables {hi,lo}
//   port_d         write word
//   port_we        high while a request is outstanding
//   rom_loaded     sticky: download finished and fully flushed
//   core_reset     registered core reset
//   overflow       sticky: a word was dropped because the FIFO was full
//   checksum       (ROM_DL_CHECKSUM_EN only) wrapping sum of accepted bytes
module rom_dl_sched #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  DL_INDEX   = 8'h00
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic        port_req,
  input  logic        port_ack,
  output logic [22:0] port_a,
  output logic [1:0]  port_ds,
  output logic [15:0] port_d,
  output logic        port_we,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow
`ifdef ROM_DL_CHECKSUM_EN
  ,
  output logic [15:0] checksum
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t state_q, state_d;

  // Edge detection on the strobe and the download flag
  logic wr_d, dl_d;
  logic accept, dl_rise, dl_fall;
  logic [22:0] byte_wa;

  // Pending even byte
  logic        pend_valid;
  logic [22:0] pend_a;
  logic [7:0]  pend_b;
  logic        pend_set, pend_clr;

  // Enqueue request
  logic        enq;
  logic [22:0] enq_a;
  logic [1:0]  enq_ds;
  logic [15:0] enq_d;

  // FIFO: entry = {a[22:0], ds[1:0], d[15:0]}
  logic [40:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          fifo_full, fifo_empty, push, pop;
  logic [40:0]   head;

  logic dl_seen;
  logic unused_addr_msb;

  assign unused_addr_msb = ioctl_addr[24];

  always_ff @(posedge clk_sys) begin
    wr_d <= ioctl_wr;
    dl_d <= ioctl_download;
  end

  assign accept  = ioctl_wr & ~wr_d & ioctl_download & (ioctl_index == DL_INDEX);
  assign dl_rise = ioctl_download & ~dl_d;
  assign dl_fall = ~ioctl_download & dl_d;
  assign byte_wa = ioctl_addr[23:1];

  // Byte packing. The displaced pending byte is enqueued in the same cycle the
  // new even byte is latched, so each accept costs at most one enqueue.
  always_comb begin
    enq      = 1'b0;
    enq_a    = '0;
    enq_ds   = '0;
    enq_d    = '0;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    if (accept) begin
      if (!ioctl_addr[0]) begin
        pend_set = 1'b1;
        if (pend_valid) begin
          enq    = 1'b1;
          enq_a  = pend_a;
          enq_ds = 2'b01;
          enq_d  = {pend_b, pend_b};
        end
      end else if (pend_valid && (pend_a == byte_wa)) begin
        enq      = 1'b1;
        enq_a    = byte_wa;
        enq_ds   = 2'b11;
        enq_d    = {ioctl_dout, pend_b};
        pend_clr = 1'b1;
      end else begin
        enq    = 1'b1;
        enq_a  = byte_wa;
        enq_ds = 2'b10;
        enq_d  = {ioctl_dout, ioctl_dout};
      end
    end else if (dl_fall && pend_valid) begin
      enq      = 1'b1;
      enq_a    = pend_a;
      enq_ds   = 2'b01;
      enq_d    = {pend_b, pend_b};
      pend_clr = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_a     <= '0;
      pend_b     <= '0;
    end else if (pend_set) begin
      pend_valid <= 1'b1;
      pend_a     <= byte_wa;
      pend_b     <= ioctl_dout;
    end else if (pend_clr) begin
      pend_valid <= 1'b0;
    end
  end

  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = enq & ~fifo_full;
  assign head       = fifo_mem[rptr];

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wptr] <= {enq_a, enq_ds, enq_d};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (enq && fifo_full) overflow <= 1'b1;
    end
  end

  // Scheduler: state register
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Scheduler: next state and pop strobe
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty)
          state_d = S_ISSUE;
        else if (!ioctl_download && !pend_valid && dl_seen)
          state_d = S_DONE;
      end
      S_ISSUE: begin
        pop     = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (port_ack == port_req) state_d = S_IDLE;
      end
      S_DONE: begin
        if (dl_rise) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // SDRAM port registers and status flags. On reset port_req copies port_ack
  // so the idle handshake reads as complete and nothing is requested.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      port_req   <= port_ack;
      port_we    <= 1'b0;
      port_a     <= '0;
      port_ds    <= '0;
      port_d     <= '0;
      dl_seen    <= 1'b0;
      rom_loaded <= 1'b0;
    end else begin
      if (state_q == S_ISSUE) begin
        port_a   <= head[40:18];
        port_ds  <= head[17:16];
        port_d   <= head[15:0];
        port_req <= ~port_req;
        port_we  <= 1'b1;
      end
      if ((state_q == S_WAIT) && (port_ack == port_req)) port_we <= 1'b0;
      if (state_q == S_DONE) rom_loaded <= 1'b1;
      if ((state_q == S_DONE) && dl_rise)
        dl_seen <= 1'b0;
      else if (ioctl_download && (state_q != S_DONE))
        dl_seen <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    core_reset <= reset | user_reset | ~rom_loaded;
  end

`ifdef ROM_DL_CHECKSUM_EN
  // Sums every accepted byte, including ones later dropped by a full FIFO
  always_ff @(posedge clk_sys) begin
    if (reset)
      checksum <= '0;
    else if (dl_rise)
      checksum <= accept ? {8'h00, ioctl_dout} : '0;
    else if (accept)
      checksum <= checksum + {8'h00, ioctl_dout};
  end
`endif

endmodule
